// File: rtl/controlador_7seg.sv
// Four-digit common-anode 7-segment scanner. Packed BCD and decimal points are
// shadowed once per full scan so a displayed number never changes mid-scan.
module controlador_7seg #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IN_BCD,
  input  logic [3:0]  DP_IN,
  input  logic        BLANK_EN,
  input  logic        EN,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int              CW       = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [6:0]      SEG_OFF  = 7'b1111111;
  localparam logic [6:0]      SEG_DASH = 7'b0111111;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_sh_bcd;
  logic [3:0]    r_sh_dp;
  logic          r_first;

  logic          w_slot_end;
  logic          w_capture;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_dec;
  logic          w_z3;
  logic          w_z32;
  logic          w_z321;
  logic          w_blank;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  assign w_slot_end = (r_cnt == CNT_LAST);
  // The first edge after reset fills the shadow; afterwards only the last
  // cycle of digit 3 does, so digit 0 of the next scan sees the new value.
  assign w_capture  = r_first || (w_slot_end && (r_idx == 2'd3));

  always_comb begin
    w_nib = r_sh_bcd[3:0];
    case (r_idx)
      2'd0: w_nib = r_sh_bcd[3:0];
      2'd1: w_nib = r_sh_bcd[7:4];
      2'd2: w_nib = r_sh_bcd[11:8];
      2'd3: w_nib = r_sh_bcd[15:12];
      default: w_nib = r_sh_bcd[3:0];
    endcase
  end

  always_comb begin
    w_seg_dec = SEG_DASH;
    case (w_nib)
      4'd0: w_seg_dec = 7'b1000000;
      4'd1: w_seg_dec = 7'b1111001;
      4'd2: w_seg_dec = 7'b0100100;
      4'd3: w_seg_dec = 7'b0110000;
      4'd4: w_seg_dec = 7'b0011001;
      4'd5: w_seg_dec = 7'b0010010;
      4'd6: w_seg_dec = 7'b0000010;
      4'd7: w_seg_dec = 7'b1111000;
      4'd8: w_seg_dec = 7'b0000000;
      4'd9: w_seg_dec = 7'b0010000;
      default: w_seg_dec = SEG_DASH;
    endcase
  end

  // Invalid nibbles are nonzero, so they stop the leading-zero run.
  assign w_z3   = (r_sh_bcd[15:12] == 4'd0);
  assign w_z32  = w_z3  && (r_sh_bcd[11:8] == 4'd0);
  assign w_z321 = w_z32 && (r_sh_bcd[7:4]  == 4'd0);

  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd3: w_blank = w_z3;
      2'd2: w_blank = w_z32;
      2'd1: w_blank = w_z321;
      default: w_blank = 1'b0;
    endcase
  end

  always_comb begin
    w_an  = 4'b1111;
    w_seg = SEG_OFF;
    w_dp  = 1'b1;
    if (EN && !r_first) begin
      w_an        = 4'b1111;
      w_an[r_idx] = 1'b0;
      w_seg       = (BLANK_EN && w_blank) ? SEG_OFF : w_seg_dec;
      w_dp        = ~r_sh_dp[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_sh_bcd <= 16'h0000;
      r_sh_dp  <= 4'h0;
      r_first  <= 1'b1;
      an       <= 4'b1111;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        r_sh_bcd <= IN_BCD;
        r_sh_dp  <= DP_IN;
      end
      an  <= w_an;
      seg <= w_seg;
      dp  <= w_dp;
    end
  end

endmodule

// File: tb/tb_controlador_7seg.sv
// Directed bench for controlador_7seg with DIV=4: every cycle is checked
// against a timing-formula model, plus hand-computed spot checks.
module tb_controlador_7seg;

  localparam int DIV  = 4;
  localparam int SCAN = 4 * DIV;
  localparam logic [11:0] DARK = 12'b1111_1111111_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IN_BCD;
  logic [3:0]  DP_IN;
  logic        BLANK_EN;
  logic        EN;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;
  logic [15:0] m_sh = 16'h0000;
  logic [3:0]  m_dp = 4'h0;

  controlador_7seg #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .IN_BCD(IN_BCD), .DP_IN(DP_IN),
    .BLANK_EN(BLANK_EN), .EN(EN), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got an_seg_dp=%b want %b", tag, k, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [11:0] exp_out(input int idx, input logic [15:0] sh,
                                          input logic [3:0] dps, input logic en,
                                          input logic blk);
    logic [3:0] a;
    logic [6:0] s;
    logic z3, z2, z1;
    if (!en) return DARK;
    a  = ~(4'b0001 << idx);
    s  = seg_of(sh[idx*4 +: 4]);
    z3 = (sh[15:12] == 4'd0);
    z2 = z3 && (sh[11:8] == 4'd0);
    z1 = z2 && (sh[7:4] == 4'd0);
    if (blk && ((idx == 3 && z3) || (idx == 2 && z2) || (idx == 1 && z1)))
      s = 7'b1111111;
    return {a, s, ~dps[idx]};
  endfunction

  // Output after edge k (k>=2) reflects idx after edge k-1 = ((k-1)/DIV)%4;
  // the shadow reloads at edge 1 and at every multiple of SCAN.
  task automatic tick();
    logic [11:0] e;
    @(posedge clk);
    if (rst) begin
      k    = 0;
      m_sh = 16'h0000;
      m_dp = 4'h0;
      e    = DARK;
    end else begin
      k++;
      if (k == 1) e = DARK;
      else        e = exp_out(((k - 1) / DIV) % 4, m_sh, m_dp, EN, BLANK_EN);
      if (k == 1 || (k % SCAN) == 0) begin
        m_sh = IN_BCD;
        m_dp = DP_IN;
      end
    end
    #1;
    chk("scan", {an, seg, dp}, e);
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  initial begin
    rst      = 1'b1;
    IN_BCD   = 16'h1234;
    DP_IN    = 4'b0000;
    BLANK_EN = 1'b0;
    EN       = 1'b1;
    repeat (3) tick();
    chk("reset_dark", {an, seg, dp}, DARK);
    rst = 1'b0;

    tick();
    chk("edge1_dark", {an, seg, dp}, DARK);
    run_to(2);
    chk("edge2_d0", {an, seg, dp}, 12'b1110_0011001_1);
    run_to(5);
    chk("d1_is_3", {an, seg, dp}, 12'b1101_0110000_1);

    run_to(21);
    IN_BCD = 16'h5678;
    run_to(25);
    chk("tear_d2_old", {an, seg, dp}, 12'b1011_0100100_1);
    run_to(32);
    chk("tear_d3_old", {an, seg, dp}, 12'b0111_1111001_1);
    run_to(33);
    chk("new_d0_is_8", {an, seg, dp}, 12'b1110_0000000_1);
    run_to(48);

    BLANK_EN = 1'b1;
    IN_BCD   = 16'h0005;
    run_to(65);
    chk("blk5_d0", {an, seg, dp}, 12'b1110_0010010_1);
    run_to(77);
    chk("blk5_d3", {an, seg, dp}, 12'b0111_1111111_1);
    run_to(80);

    IN_BCD = 16'h0000;
    run_to(97);
    chk("blk0_d0", {an, seg, dp}, 12'b1110_1000000_1);
    run_to(101);
    chk("blk0_d1", {an, seg, dp}, 12'b1101_1111111_1);
    run_to(112);

    IN_BCD = 16'h0A05;
    run_to(133);
    chk("blkA_d1", {an, seg, dp}, 12'b1101_1000000_1);
    run_to(137);
    chk("blkA_d2_dash", {an, seg, dp}, 12'b1011_0111111_1);
    run_to(141);
    chk("blkA_d3", {an, seg, dp}, 12'b0111_1111111_1);
    run_to(144);

    BLANK_EN = 1'b0;
    IN_BCD   = 16'h1234;
    DP_IN    = 4'b0100;
    run_to(165);
    chk("dp_off_d1", {an, seg, dp}, 12'b1101_0110000_1);
    run_to(169);
    chk("dp_on_d2", {an, seg, dp}, 12'b1011_0100100_0);
    run_to(178);

    EN = 1'b0;
    run_to(179);
    chk("en_dark", {an, seg, dp}, DARK);
    run_to(188);
    EN = 1'b1;
    run_to(189);
    chk("en_resume", {an, seg, dp}, 12'b0111_1111001_1);
    run_to(202);

    rst    = 1'b1;
    IN_BCD = 16'h4321;
    tick();
    chk("midslot_rst", {an, seg, dp}, DARK);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_edge1_dark", {an, seg, dp}, DARK);
    run_to(2);
    chk("rst_edge2_d0", {an, seg, dp}, 12'b1110_1111001_1);
    run_to(5);
    chk("rst_d1", {an, seg, dp}, 12'b1101_0100100_1);
    run_to(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got k=%0d", k);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
